serial_pattern_tx: RTL and testbench

- Parallel-to-serial bit-stream generator that drives the single-bit `s_in` input of the serial sequence-detector FSM.
- Accepts a word plus a bit count over a valid/ready handshake and shifts the bits out one per clock.
- Can insert idle gap cycles between words, or stream words back-to-back so that detector patterns span word boundaries.
- Used as a synthesizable stimulus source in block benches and as the transmit end of the serial link.

---
 rtl/serial_tx_pkg.sv | 12 +
 rtl/serial_tx_shreg.sv | 35 +++
 rtl/serial_pattern_tx.sv | 89 ++++++++
 tb/tb_serial_pattern_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state type and length helpers for the serial pattern transmitter
package serial_tx_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    function automatic int cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    function automatic int clamp_len(input int len, input int data_w);
        return (len == 0 || len > data_w) ? data_w : len;
    endfunction
endpackage

// File: rtl/serial_tx_shreg.sv
// serial_tx_shreg: loadable shift register presenting the next serial bit from a fixed end
module serial_tx_shreg
    import serial_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic                       shift,
    input  logic [DATA_W-1:0]          data,
    input  logic [cnt_w(DATA_W)-1:0]   len,
    output logic                       next_bit
);
    localparam int LW = cnt_w(DATA_W);

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] src;
    logic [LW-1:0]     shamt;

    assign shamt    = LW'(DATA_W) - len;
    assign aligned  = MSB_FIRST ? data << shamt : data;
    assign src      = load ? aligned : sr;
    assign next_bit = MSB_FIRST ? src[DATA_W-1] : src[0];

    // The bit leaving now is consumed; keep the remainder for the following cycles
    always_ff @(posedge clk) begin
        if (!rst_n)
            sr <= '0;
        else if (load || shift)
            sr <= MSB_FIRST ? src << 1 : src >> 1;
    end
endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: parallel-to-serial bit-stream generator with optional inter-word gap
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 0,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [cnt_w(DATA_W)-1:0] in_len,
    output logic                     s_out,
    output logic                     s_out_en,
    output logic                     busy,
    output logic                     done
);
    localparam int LW = cnt_w(DATA_W);

    state_t        state;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_c;
    logic [3:0]    gap;
    logic          accept;
    logic          shift;
    logic          next_bit;

    assign len_c    = LW'(clamp_len(int'(in_len), DATA_W));
    assign in_ready = state == IDLE || (GAP_CYCLES == 0 && state == SHIFT && cnt == '0);
    assign accept   = in_valid && in_ready;
    assign shift    = state == SHIFT && cnt != '0;

    serial_tx_shreg #(
        .DATA_W   (DATA_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .shift   (shift),
        .data    (in_data),
        .len     (len_c),
        .next_bit(next_bit)
    );

    // The idle cycle that ends a gap counts as its last gap cycle, so GAP itself lasts GAP_CYCLES-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gap      <= '0;
            s_out    <= IDLE_LEVEL;
            s_out_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (accept) begin
            state    <= SHIFT;
            cnt      <= len_c - LW'(1);
            s_out    <= next_bit;
            s_out_en <= 1'b1;
            busy     <= 1'b1;
            done     <= len_c == LW'(1);
        end else if (shift) begin
            cnt      <= cnt - LW'(1);
            s_out    <= next_bit;
            s_out_en <= 1'b1;
            busy     <= 1'b1;
            done     <= cnt == LW'(1);
        end else begin
            s_out    <= IDLE_LEVEL;
            s_out_en <= 1'b0;
            done     <= 1'b0;
            if (state == SHIFT && GAP_CYCLES > 1) begin
                state <= GAP;
                gap   <= 4'(GAP_CYCLES - 2);
                busy  <= 1'b1;
            end else if (state == GAP && gap != '0) begin
                gap  <= gap - 4'd1;
                busy <= 1'b1;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed vector checks of the serial pattern transmitter
module tb_serial_pattern_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_valid = 1'b0, a_ready, a_out, a_en, a_busy, a_done;
    logic [7:0] a_data = '0;
    logic [3:0] a_len = '0;
    logic       b_valid = 1'b0, b_ready, b_out, b_en, b_busy, b_done;
    logic [7:0] b_data = '0;
    logic [3:0] b_len = '0;

    serial_pattern_tx #(.DATA_W(8), .GAP_CYCLES(0), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_len(a_len), .s_out(a_out), .s_out_en(a_en), .busy(a_busy), .done(a_done)
    );

    serial_pattern_tx #(.DATA_W(8), .GAP_CYCLES(3), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_len(b_len), .s_out(b_out), .s_out_en(b_en), .busy(b_busy), .done(b_done)
    );

    // expected outputs packed as {in_ready, busy, s_out_en, done, s_out}
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] l;
        logic [4:0] e;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b ({ready,busy,en,done,out})", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] a_obs();
        return {a_ready, a_busy, a_en, a_done, a_out};
    endfunction

    function automatic logic [4:0] b_obs();
        return {b_ready, b_busy, b_en, b_done, b_out};
    endfunction

    logic [7:0] pat;

    initial begin
        // MSB-first 8'b1011_0010, in_len 0 means full width
        tbl.push_back('{1'b1, 8'hB2, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b11110});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b10000});
        // back-to-back 1011 then 0110, valid held high, data changed after capture
        tbl.push_back('{1'b1, 8'h0B, 4'd4, 5'b01101});
        tbl.push_back('{1'b1, 8'h06, 4'd4, 5'b01100});
        tbl.push_back('{1'b1, 8'h06, 4'd4, 5'b01101});
        tbl.push_back('{1'b1, 8'h06, 4'd4, 5'b11111});
        tbl.push_back('{1'b1, 8'h06, 4'd4, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b11110});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b10000});
        // in_len 15 clamps to 8: 0101_1010
        tbl.push_back('{1'b1, 8'h5A, 4'd15, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01100});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b01101});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b11110});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b10000});
        // single-bit word: done in its only shift cycle
        tbl.push_back('{1'b1, 8'h01, 4'd1, 5'b11111});
        tbl.push_back('{1'b0, 8'h00, 4'd0, 5'b10000});

        // reset held 8 cycles, then 20 idle cycles
        repeat (8) cyc();
        chk("reset_a", a_obs(), 5'b10000);
        chk("reset_b", b_obs(), 5'b10000);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("idle_%0d", i), a_obs(), 5'b10000);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            a_valid = tbl[i].v;
            a_data  = tbl[i].d;
            a_len   = tbl[i].l;
            cyc();
            chk($sformatf("vec_%0d", i), a_obs(), tbl[i].e);
        end

        // reset during the 3rd bit of 1011_0010
        a_valid = 1'b1; a_data = 8'hB2; a_len = 4'd8;
        cyc();
        chk("mid_bit1", a_obs(), 5'b01101);
        a_valid = 1'b0;
        cyc();
        chk("mid_bit2", a_obs(), 5'b01100);
        cyc();
        chk("mid_bit3", a_obs(), 5'b01101);
        rst_n = 1'b0;
        cyc();
        chk("mid_reset", a_obs(), 5'b10000);
        rst_n = 1'b1;
        cyc();
        chk("mid_release", a_obs(), 5'b10000);
        pat = 8'hC3;
        a_valid = 1'b1; a_data = pat; a_len = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            cyc();
            a_valid = 1'b0;
            a_data  = 8'h00;
            chk($sformatf("after_rst_bit%0d", i), a_obs(), {i == 0, 1'b1, 1'b1, i == 0, pat[i]});
        end
        cyc();
        chk("after_rst_idle", a_obs(), 5'b10000);

        // LSB-first short word (A5, len 3 -> 1,0,1) then gap of 3 before the next word
        b_valid = 1'b1; b_data = 8'hA5; b_len = 4'd3;
        cyc();
        chk("lsb_bit0", b_obs(), 5'b01101);
        b_data = 8'h03; b_len = 4'd2;
        cyc();
        chk("lsb_bit1", b_obs(), 5'b01100);
        cyc();
        chk("lsb_bit2", b_obs(), 5'b01111);
        cyc();
        chk("gap1", b_obs(), 5'b01000);
        cyc();
        chk("gap2", b_obs(), 5'b01000);
        cyc();
        chk("gap3_ready", b_obs(), 5'b10000);
        cyc();
        chk("w2_bit0", b_obs(), 5'b01101);
        b_valid = 1'b0;
        cyc();
        chk("w2_bit1", b_obs(), 5'b01111);
        cyc();
        chk("w2_gap1", b_obs(), 5'b01000);
        cyc();
        chk("w2_gap2", b_obs(), 5'b01000);
        cyc();
        chk("w2_idle", b_obs(), 5'b10000);
        repeat (5) cyc();
        chk("b_hold_idle", b_obs(), 5'b10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
